// File: rtl/ro_seq_pkg.sv
// Shared types and helpers for the ring-oscillator bank sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package ro_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PICK     = 3'd1,
        S_CLEAR    = 3'd2,
        S_COLLECT  = 3'd3,
        S_READ     = 3'd4,
        S_WAIT_RES = 3'd5,
        S_DONE     = 3'd6
    } seq_state_t;

    // Width of a bank index for n banks (n >= 2).
    function automatic int bank_id_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/rr_next_bank.sv
// Round-robin search: next set mask bit strictly after prev, wrapping around.
// Latency: purely combinational.
// Backpressure: none.
// Ports: mask (candidate banks), prev (last served index),
//        next (chosen index), found (mask had at least one bit set).
module rr_next_bank #(
    parameter int N  = 4,
    parameter int BW = 2
) (
    input  logic [N-1:0]  mask,
    input  logic [BW-1:0] prev,
    output logic [BW-1:0] next,
    output logic          found
);

    always_comb begin
        next  = '0;
        found = 1'b0;
        // Offsets 1..N; offset N lands back on prev itself, so a single-bit
        // mask keeps selecting the same bank.
        for (int i = 1; i <= N; i++) begin
            int j;
            j = int'(prev) + i;
            if (j >= N) j = j - N;
            if (!found && mask[j]) begin
                found = 1'b1;
                next  = BW'(j);
            end
        end
    end

endmodule

// File: rtl/ro_bank_sequencer.sv
// Round-robin sequencer sharing one measurement path across NUM_BANKS RO banks.
// Latency: per bank 1 PICK + 1 CLEAR + max(collect_cycles,1) + 1 READ + <=RES_TIMEOUT wait.
// Backpressure: fifo_almost_full stalls in PICK before a bank sequence starts.
// Ports: go/stop control; bank_mask/num_samples/collect_cycles latched on go;
//        res_valid/res_data from each bank's add tree; bank_* per-bank strobes;
//        fifo_wr_en/fifo_wr_data = {pad, sample_idx, bank_id, result};
//        busy/done status; err_timeout sticky until the next go.
// Optional: RO_SEQ_STALL_STATS_EN adds stall_cycles (saturating PICK stall count).
module ro_bank_sequencer
    import ro_seq_pkg::*;
#(
    parameter int NUM_BANKS    = 4,
    parameter int CYCLE_WIDTH  = 10,
    parameter int SAMPLE_WIDTH = 10,
    parameter int RESULT_WIDTH = 19,
    parameter int FIFO_WIDTH   = 32,
    parameter int RES_TIMEOUT  = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    go,
    input  logic                                    stop,
    input  logic [NUM_BANKS-1:0]                    bank_mask,
    input  logic [SAMPLE_WIDTH-1:0]                 num_samples,
    input  logic [CYCLE_WIDTH-1:0]                  collect_cycles,
    input  logic                                    fifo_almost_full,
    input  logic [NUM_BANKS-1:0]                    res_valid,
    input  logic [NUM_BANKS-1:0][RESULT_WIDTH-1:0]  res_data,
    output logic [NUM_BANKS-1:0]                    bank_tree_rst,
    output logic [NUM_BANKS-1:0]                    bank_roc_rst,
    output logic [NUM_BANKS-1:0]                    bank_roc_en,
    output logic [NUM_BANKS-1:0]                    bank_roc_valid,
    output logic                                    fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]                   fifo_wr_data,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    err_timeout
`ifdef RO_SEQ_STALL_STATS_EN
    ,
    output logic [15:0]                             stall_cycles
`endif
);

    localparam int BW = bank_id_width(NUM_BANKS);
    localparam int TW = $clog2(RES_TIMEOUT + 1);

    seq_state_t state, state_nxt;

    logic [NUM_BANKS-1:0]    mask_q;
    logic [SAMPLE_WIDTH-1:0] nsamp_q;
    logic [CYCLE_WIDTH-1:0]  ccyc_q;
    logic [CYCLE_WIDTH-1:0]  win_cnt;
    logic [TW-1:0]           to_cnt;
    logic [SAMPLE_WIDTH-1:0] sample_idx;
    logic [BW-1:0]           cur_bank;
    logic [BW-1:0]           nxt_bank;
    logic                    nxt_found;
    logic [NUM_BANKS-1:0]    cur_oh;
    logic                    is_last;
    logic [SAMPLE_WIDTH-1:0] samp_inc;
    logic                    run_state;

    logic ld_go, take_pick, ld_win, dec_win, clr_to, inc_to, adv, set_err, stall, wr;

    rr_next_bank #(.N(NUM_BANKS), .BW(BW)) u_rr (
        .mask  (mask_q),
        .prev  (cur_bank),
        .next  (nxt_bank),
        .found (nxt_found)
    );

    assign cur_oh    = NUM_BANKS'(1) << cur_bank;
    // No mask bits above cur_bank means this bank closes the current pass.
    assign is_last   = ((mask_q >> cur_bank) >> 1) == '0;
    assign samp_inc  = sample_idx + SAMPLE_WIDTH'(1);
    assign run_state = (state == S_PICK) || (state == S_CLEAR) || (state == S_COLLECT) ||
                       (state == S_READ) || (state == S_WAIT_RES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        bank_tree_rst  = '0;
        bank_roc_rst   = '0;
        bank_roc_en    = '0;
        bank_roc_valid = '0;
        wr        = 1'b0;
        ld_go     = 1'b0;
        take_pick = 1'b0;
        ld_win    = 1'b0;
        dec_win   = 1'b0;
        clr_to    = 1'b0;
        inc_to    = 1'b0;
        adv       = 1'b0;
        set_err   = 1'b0;
        stall     = 1'b0;
        case (state)
            S_IDLE: begin
                if (go) begin
                    ld_go         = 1'b1;
                    bank_tree_rst = bank_mask;
                    state_nxt     = (bank_mask == '0 || num_samples == '0) ? S_DONE : S_PICK;
                end
            end
            S_PICK: begin
                if (fifo_almost_full) begin
                    stall = 1'b1;
                end else begin
                    take_pick = nxt_found;
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                bank_roc_rst = cur_oh;
                ld_win       = 1'b1;
                state_nxt    = S_COLLECT;
            end
            S_COLLECT: begin
                bank_roc_en = cur_oh;
                if (win_cnt <= CYCLE_WIDTH'(1)) state_nxt = S_READ;
                else                            dec_win   = 1'b1;
            end
            S_READ: begin
                bank_roc_valid = cur_oh;
                clr_to         = 1'b1;
                state_nxt      = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                if (res_valid[cur_bank]) begin
                    wr  = 1'b1;
                    adv = 1'b1;
                end else if (to_cnt == TW'(RES_TIMEOUT - 1)) begin
                    set_err = 1'b1;
                    adv     = 1'b1;
                end else begin
                    inc_to = 1'b1;
                end
                if (adv) state_nxt = (is_last && samp_inc == nsamp_q) ? S_DONE : S_PICK;
            end
            S_DONE: begin
                if (!go) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // Abort kills this cycle's strobes and side effects outright.
        if (stop && run_state) begin
            state_nxt      = S_DONE;
            bank_roc_rst   = '0;
            bank_roc_en    = '0;
            bank_roc_valid = '0;
            wr        = 1'b0;
            take_pick = 1'b0;
            ld_win    = 1'b0;
            dec_win   = 1'b0;
            clr_to    = 1'b0;
            inc_to    = 1'b0;
            adv       = 1'b0;
            set_err   = 1'b0;
            stall     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q      <= '0;
            nsamp_q     <= '0;
            ccyc_q      <= '0;
            win_cnt     <= '0;
            to_cnt      <= '0;
            sample_idx  <= '0;
            cur_bank    <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (ld_go) begin
                mask_q      <= bank_mask;
                nsamp_q     <= num_samples;
                ccyc_q      <= collect_cycles;
                sample_idx  <= '0;
                err_timeout <= 1'b0;
                // Searching strictly after the top index wraps to bit 0 first.
                cur_bank    <= BW'(NUM_BANKS - 1);
            end
            if (take_pick) cur_bank <= nxt_bank;
            if (ld_win)    win_cnt  <= (ccyc_q == '0) ? CYCLE_WIDTH'(1) : ccyc_q;
            if (dec_win)   win_cnt  <= win_cnt - CYCLE_WIDTH'(1);
            if (clr_to)    to_cnt   <= '0;
            if (inc_to)    to_cnt   <= to_cnt + TW'(1);
            if (set_err)   err_timeout <= 1'b1;
            if (adv && is_last) sample_idx <= samp_inc;
        end
    end

`ifdef RO_SEQ_STALL_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   stall_cycles <= '0;
        else if (ld_go)                            stall_cycles <= '0;
        else if (stall && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
    end
`endif

    assign fifo_wr_en   = wr;
    assign fifo_wr_data = wr ? FIFO_WIDTH'({sample_idx, cur_bank, res_data[cur_bank]}) : '0;
    assign busy         = run_state;
    assign done         = (state == S_DONE);

endmodule
